// File: rtl/framebuffer_bar_writer_pkg.sv
// Shared visualizer definitions: screen geometry (also used by the VGA scan-out),
// the bar writer FSM state type and the framebuffer address-width helper.
package framebuffer_bar_writer_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW,
    DONE
  } state_t;

  function automatic int fb_addr_width(input int width, input int height);
    return $clog2(width * height);
  endfunction

endpackage

// File: rtl/framebuffer_bar_writer_raster.sv
// Row-major raster walker: y, bar index/column within the bar pitch, and the
// linear framebuffer address, all stepped incrementally so no divider is needed.
module framebuffer_bar_writer_raster
  import framebuffer_bar_writer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_W,
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter int BAR_WIDTH     = 20
) (
  input  logic                                                  clk,
  input  logic                                                  resetn,
  input  logic                                                  clear,
  input  logic                                                  advance,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]                      y,
  output logic [$clog2(SCREEN_WIDTH/BAR_WIDTH+1)-1:0]           bar_idx,
  output logic [$clog2(BAR_WIDTH)-1:0]                          bar_col,
  output logic [fb_addr_width(SCREEN_WIDTH, SCREEN_HEIGHT)-1:0] addr
);

  localparam int X_W    = $clog2(SCREEN_WIDTH);
  localparam int Y_W    = $clog2(SCREEN_HEIGHT);
  localparam int COL_W  = $clog2(BAR_WIDTH);
  localparam int ADDR_W = fb_addr_width(SCREEN_WIDTH, SCREEN_HEIGHT);

  logic [X_W-1:0] x;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      x       <= '0;
      y       <= '0;
      bar_idx <= '0;
      bar_col <= '0;
      addr    <= '0;
    end else if (advance) begin
      addr <= (addr == ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1)) ? '0 : addr + 1'b1;
      if (x == X_W'(SCREEN_WIDTH - 1)) begin
        // Row wrap: the bar tracking restarts with the row.
        x       <= '0;
        bar_idx <= '0;
        bar_col <= '0;
        y       <= (y == Y_W'(SCREEN_HEIGHT - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
        if (bar_col == COL_W'(BAR_WIDTH - 1)) begin
          bar_col <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_col <= bar_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/framebuffer_bar_writer.sv
// Renders one frame of vertical spectrum bars into the 1-bit framebuffer:
// snapshot all bin magnitudes, then write every pixel once, one per clock.
module framebuffer_bar_writer
  import framebuffer_bar_writer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_W,
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter int NUM_BARS      = 32,
  parameter int BAR_WIDTH     = 20,
  parameter int BAR_GAP       = 2,
  parameter int MAG_WIDTH     = 16,
  parameter int MAG_SHIFT     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  resetn,
  input  logic                                                  start,
  output logic                                                  bin_rd_en,
  output logic [$clog2(NUM_BARS)-1:0]                           bin_addr,
  input  logic [MAG_WIDTH-1:0]                                  bin_data,
  output logic                                                  fb_wr_en,
  output logic [fb_addr_width(SCREEN_WIDTH, SCREEN_HEIGHT)-1:0] fb_wr_addr,
  output logic                                                  fb_wr_data,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int ADDR_W = fb_addr_width(SCREEN_WIDTH, SCREEN_HEIGHT);
  localparam int BIN_W  = $clog2(NUM_BARS);
  localparam int LCNT_W = $clog2(NUM_BARS + 1);
  localparam int HGT_W  = $clog2(SCREEN_HEIGHT + 1);
  localparam int Y_W    = $clog2(SCREEN_HEIGHT);
  localparam int BIDX_W = $clog2(SCREEN_WIDTH / BAR_WIDTH + 1);
  localparam int COL_W  = $clog2(BAR_WIDTH);

  state_t              state, next_state;
  logic [LCNT_W-1:0]   load_cnt;
  logic [HGT_W-1:0]    height [NUM_BARS];
  logic                rd_en_next;
  logic [BIN_W-1:0]    bin_addr_next;
  logic                emit;

  logic [Y_W-1:0]      y;
  logic [BIDX_W-1:0]   bar_idx;
  logic [COL_W-1:0]    bar_col;
  logic [ADDR_W-1:0]   pix_addr;

  logic [MAG_WIDTH-1:0] raw_height;
  logic [HGT_W-1:0]     clamped_height;
  logic [HGT_W-1:0]     row_up;
  logic [BIN_W-1:0]     bar_sel;
  logic                 pixel_on;

  framebuffer_bar_writer_raster #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .BAR_WIDTH    (BAR_WIDTH)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == IDLE),
    .advance(emit),
    .y      (y),
    .bar_idx(bar_idx),
    .bar_col(bar_col),
    .addr   (pix_addr)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    rd_en_next    = 1'b0;
    bin_addr_next = '0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
          rd_en_next = 1'b1;
        end
      end
      LOAD: begin
        if (load_cnt == LCNT_W'(NUM_BARS)) begin
          next_state = DRAW;
        end else if (load_cnt < LCNT_W'(NUM_BARS - 1)) begin
          rd_en_next    = 1'b1;
          bin_addr_next = BIN_W'(load_cnt + 1'b1);
        end
      end
      DRAW:    if (fb_wr_addr == ADDR_W'(PIXELS - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The pixel for the next write is computed from the raster counters and
  // registered together with its address and strobe.
  always_comb begin
    emit           = (next_state == DRAW);
    raw_height     = bin_data >> MAG_SHIFT;
    clamped_height = (raw_height > MAG_WIDTH'(SCREEN_HEIGHT)) ? HGT_W'(SCREEN_HEIGHT)
                                                              : HGT_W'(raw_height);
    row_up         = HGT_W'(SCREEN_HEIGHT - 1) - HGT_W'(y);
    bar_sel        = (bar_idx < BIDX_W'(NUM_BARS)) ? bar_idx[BIN_W-1:0] : '0;
    pixel_on       = (bar_idx < BIDX_W'(NUM_BARS)) &&
                     (bar_col < COL_W'(BAR_WIDTH - BAR_GAP)) &&
                     (row_up < height[bar_sel]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      load_cnt   <= '0;
      bin_rd_en  <= 1'b0;
      bin_addr   <= '0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      // NOTE: the height file is a small flop array, so it is cleared on reset;
      // a block-RAM store would not be.
      for (int i = 0; i < NUM_BARS; i++) height[i] <= '0;
    end else begin
      state      <= next_state;
      load_cnt   <= (state == LOAD) ? load_cnt + 1'b1 : '0;
      bin_rd_en  <= rd_en_next;
      bin_addr   <= bin_addr_next;
      fb_wr_en   <= emit;
      fb_wr_addr <= emit ? pix_addr : '0;
      fb_wr_data <= emit && pixel_on;
      busy       <= (next_state != IDLE);
      done       <= (next_state == DONE);
      // Read data for bin k arrives in LOAD cycle k+1.
      if (state == LOAD && load_cnt != '0) begin
        height[BIN_W'(load_cnt - 1'b1)] <= clamped_height;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_bar_writer.sv
// Directed bench for framebuffer_bar_writer on a reduced screen (128x48, 6 bars)
// so each render is a few thousand cycles; bar pitch/gap/shift keep their defaults.
module tb_framebuffer_bar_writer;

  localparam int W     = 128;
  localparam int H     = 48;
  localparam int NB    = 6;
  localparam int BW    = 20;
  localparam int GAP   = 2;
  localparam int MW    = 16;
  localparam int SHIFT = 4;
  localparam int P     = W * H;
  localparam int AW    = $clog2(P);
  localparam int BINW  = $clog2(NB);

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            bin_rd_en;
  logic [BINW-1:0] bin_addr;
  logic [MW-1:0]   bin_data = '0;
  logic            fb_wr_en;
  logic [AW-1:0]   fb_wr_addr;
  logic            fb_wr_data;
  logic            busy;
  logic            done;

  logic [MW-1:0] mag  [NB];
  logic [MW-1:0] snap [NB];

  int errors = 0;
  int checks = 0;

  framebuffer_bar_writer #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .NUM_BARS     (NB),
    .BAR_WIDTH    (BW),
    .BAR_GAP      (GAP),
    .MAG_WIDTH    (MW),
    .MAG_SHIFT    (SHIFT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .bin_rd_en (bin_rd_en),
    .bin_addr  (bin_addr),
    .bin_data  (bin_data),
    .fb_wr_en  (fb_wr_en),
    .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Bin store: registered read, data valid the cycle after the strobe.
  always @(posedge clk) if (bin_rd_en) bin_data <= mag[bin_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit exp_pixel(input int a);
    int x, y, bar, col, h;
    x   = a % W;
    y   = a / W;
    bar = x / BW;
    col = x % BW;
    if (bar >= NB || col >= BW - GAP) return 1'b0;
    h = int'(snap[bar]) >> SHIFT;
    if (h > H) h = H;
    return (H - 1 - y) < h;
  endfunction

  // mode 0: plain render; 1: start poked mid-DRAW and during DONE, magnitudes
  // changed mid-frame; 2: restart one cycle after done; 3: reset at pixel 1000.
  task automatic run_render(input string name, input int mode, input bit pre_started,
                            input int exp_lit, input int exp_first_lit, input int exp_last_lit);
    int cyc, wr_cnt, rd_cnt, lit, first_lit, last_lit, first_wr, done_cyc;
    int addr_err, data_err, rd_err, busy_err;
    bit aborted;
    if (!pre_started) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    snap = mag;
    cyc = 1; wr_cnt = 0; rd_cnt = 0; lit = 0; first_lit = -1; last_lit = -1;
    first_wr = -1; done_cyc = -1; addr_err = 0; data_err = 0; rd_err = 0; busy_err = 0;
    aborted = 1'b0;
    while (1) begin
      if (bin_rd_en === 1'b1) begin
        if (int'(bin_addr) != rd_cnt || cyc != rd_cnt + 1) rd_err++;
        rd_cnt++;
      end
      if (busy !== 1'b1) busy_err++;
      if (fb_wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        if (int'(fb_wr_addr) != wr_cnt) addr_err++;
        if (fb_wr_data !== exp_pixel(wr_cnt)) data_err++;
        if (fb_wr_data === 1'b1) begin
          lit++;
          if (first_lit < 0) first_lit = int'(fb_wr_addr);
          last_lit = int'(fb_wr_addr);
        end
        wr_cnt++;
        if (mode == 3 && int'(fb_wr_addr) == 1000) begin
          aborted = 1'b1;
          break;
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > NB + P + 20) break;
      if (mode == 1 && cyc == NB + 2 + 500) begin
        start = 1'b1;
        for (int i = 0; i < NB; i++) mag[i] = '1;
      end
      if (mode == 1 && cyc == NB + 3 + 500) start = 1'b0;
      @(negedge clk);
      cyc++;
    end

    if (aborted) begin
      resetn = 1'b0;
      @(negedge clk);
      check({name, ".rst_outs"},
            {bin_rd_en, bin_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy, done}, 0);
      resetn = 1'b1;
      check({name, ".addr_err"}, addr_err, 0);
      check({name, ".data_err"}, data_err, 0);
      return;
    end
    if (done_cyc < 0) begin
      check({name, ".done_timeout"}, 0, 1);
      return;
    end

    check({name, ".wr_count"}, wr_cnt, P);
    check({name, ".addr_err"}, addr_err, 0);
    check({name, ".data_err"}, data_err, 0);
    check({name, ".lit_count"}, lit, exp_lit);
    check({name, ".first_wr_cycle"}, first_wr, NB + 2);
    check({name, ".done_cycle"}, done_cyc, NB + 2 + P);
    check({name, ".rd_count"}, rd_cnt, NB);
    check({name, ".rd_err"}, rd_err, 0);
    check({name, ".busy_err"}, busy_err, 0);
    if (exp_first_lit >= 0) begin
      check({name, ".first_lit"}, first_lit, exp_first_lit);
      check({name, ".last_lit"}, last_lit, exp_last_lit);
    end

    case (mode)
      1: begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ".idle_after_done"}, {busy, done}, 0);
        @(negedge clk);
        check({name, ".no_restart"}, {busy, bin_rd_en}, 0);
      end
      2: begin
        @(negedge clk);
        check({name, ".idle_after_done"}, {busy, done}, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ".chain_load"}, {busy, bin_rd_en, bin_addr}, {2'b11, BINW'(0)});
      end
      default: begin
        @(negedge clk);
        check({name, ".idle_after_done"}, {busy, done}, 0);
      end
    endcase
  endtask

  task automatic clear_mags();
    for (int i = 0; i < NB; i++) mag[i] = '0;
  endtask

  initial begin
    clear_mags();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {bin_rd_en, bin_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy, done}, 0);
    resetn = 1'b1;

    run_render("zeros", 0, 1'b0, 0, -1, -1);

    mag[0] = 16'd768;                       // 48<<4: full height
    run_render("bin0_full", 0, 1'b0, 864, 0, 6033);

    clear_mags();
    mag[5] = 16'd16;                        // height 1: row 47, x 100..117
    run_render("bin5_h1", 2, 1'b0, 18, 6116, 6133);

    clear_mags();                           // loaded by the chained start
    mag[2] = 16'd335;                       // 20 rows
    mag[5] = 16'hFFFF;                      // 4095 saturates to 48
    run_render("sat_mid", 0, 1'b1, 1224, 100, 6133);

    clear_mags();
    mag[0] = 16'd15;                        // below one pixel
    mag[1] = 16'd784;                       // 49 saturates to 48
    mag[5] = 16'd32;                        // 2 rows
    run_render("edge_poke", 1, 1'b0, 900, 20, 6133);

    for (int i = 0; i < NB; i++) mag[i] = 16'hFFFF;
    run_render("abort", 3, 1'b0, 0, -1, -1);

    clear_mags();
    mag[0] = 16'd768;
    run_render("after_reset", 0, 1'b0, 864, 0, 6033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
